// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - bundle of CPU, secondary requester and RAM signals around the data memory arbiter
interface dmem_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  // MEM stage side
  logic              cpu_en;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;
  // secondary requester side
  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_ack;
  logic [DATA_W-1:0] dbg_rdata;
  // data RAM side
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // requesters and RAM
  modport master (
    output cpu_en, cpu_we, cpu_addr, cpu_wdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output mem_rdata,
    input  cpu_rdata, cpu_stall, dbg_ack, dbg_rdata,
    input  mem_we, mem_addr, mem_wdata
  );

  // the arbiter
  modport slave (
    input  cpu_en, cpu_we, cpu_addr, cpu_wdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  mem_rdata,
    output cpu_rdata, cpu_stall, dbg_ack, dbg_rdata,
    output mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - CPU-priority data memory port arbiter with starvation-forced secondary grant
module dmem_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int MAX_WAIT = 8,
  parameter int CNT_W    = 4
) (
  input  logic          i_clock,
  input  logic          i_reset,
  dmem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FORCE = 2'd1,
    ST_ACK   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LP_MAX_WAIT = CNT_W'(MAX_WAIT);

  state_t            r_state;
  state_t            w_next_state;
  logic [CNT_W-1:0]  r_wait_cnt;
  logic [CNT_W-1:0]  w_next_cnt;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic [DATA_W-1:0] r_dbg_rdata;
  logic              w_dbg_owner;
  logic              w_capture;
  logic [ADDR_W-1:0] w_mem_addr;

  assign w_cnt_inc = r_wait_cnt + CNT_W'(1);

  // next-state, starvation counter update and port ownership for this cycle
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_wait_cnt;
    w_dbg_owner  = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!bus.dbg_req) begin
          w_next_cnt = '0;
        end else if (!bus.cpu_en) begin
          // CPU is not using the port: hand it to the secondary for free
          w_dbg_owner  = 1'b1;
          w_capture    = 1'b1;
          w_next_cnt   = '0;
          w_next_state = ST_ACK;
        end else begin
          w_next_cnt = w_cnt_inc;
          if (w_cnt_inc == LP_MAX_WAIT) begin
            w_next_state = ST_FORCE;
          end
        end
      end
      ST_FORCE: begin
        // pipeline is frozen this cycle, so the CPU access simply replays next cycle
        w_dbg_owner  = 1'b1;
        w_capture    = 1'b1;
        w_next_cnt   = '0;
        w_next_state = ST_ACK;
      end
      ST_ACK: begin
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_cnt   = '0;
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // state register, starvation counter and captured secondary read data
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_wait_cnt  <= '0;
      r_dbg_rdata <= '0;
    end else begin
      r_state    <= w_next_state;
      r_wait_cnt <= w_next_cnt;
      if (w_capture) begin
        r_dbg_rdata <= bus.mem_rdata;
      end
    end
  end

  assign w_mem_addr    = w_dbg_owner ? bus.dbg_addr : bus.cpu_addr;
  assign bus.mem_addr  = w_mem_addr;
  assign bus.mem_wdata = w_dbg_owner ? bus.dbg_wdata : bus.cpu_wdata;
  assign bus.mem_we    = i_reset ? 1'b0
                       : (w_dbg_owner ? bus.dbg_we : (bus.cpu_en & bus.cpu_we));

  assign bus.cpu_rdata = bus.mem_rdata;
  assign bus.cpu_stall = (r_state == ST_FORCE);
  assign bus.dbg_ack   = (r_state == ST_ACK);
  assign bus.dbg_rdata = r_dbg_rdata;

endmodule
